// File: rtl/servo_pulse_if.sv
// Signal bundle between a servo pulse source and the pulse decoder.
// The source drives pulse_in; the decoder returns the measurement and status.
interface servo_pulse_if;
  logic        pulse_in;
  logic [20:0] width;
  logic [1:0]  direction;
  logic        valid;
  logic        error;
  logic        timeout;

  modport master (
    output pulse_in,
    input  width, direction, valid, error, timeout
  );

  modport slave (
    input  pulse_in,
    output width, direction, valid, error, timeout
  );
endinterface

// File: rtl/servo_pulse_decoder.sv
// Measures the high time of a 1-2 ms servo pulse and decodes it to a direction code.
// A loss-of-signal watchdog forces the neutral code when rising edges stop arriving.
module servo_pulse_decoder #(
  parameter int unsigned CLK_RATE      = 100000000,
  parameter int unsigned MIN_WIDTH     = 80000,
  parameter int unsigned FWD_MAX       = 125000,
  parameter int unsigned REV_MIN       = 175000,
  parameter int unsigned MAX_WIDTH     = 220000,
  parameter int unsigned FRAME_TIMEOUT = 3000000
) (
  input  logic          clk,
  input  logic          rst,
  servo_pulse_if.slave  bus
);

  localparam int unsigned FCNT_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [20:0]       MIN_W    = 21'(MIN_WIDTH);
  localparam logic [20:0]       FWD_W    = 21'(FWD_MAX);
  localparam logic [20:0]       REV_W    = 21'(REV_MIN);
  localparam logic [20:0]       MAX_W    = 21'(MAX_WIDTH);
  localparam logic [20:0]       HCNT_MAX = '1;
  localparam logic [FCNT_W-1:0] FT       = FCNT_W'(FRAME_TIMEOUT);

  localparam logic [1:0] DIR_FWD     = 2'd0;
  localparam logic [1:0] DIR_NEUTRAL = 2'd1;
  localparam logic [1:0] DIR_REV     = 2'd2;

  if (CLK_RATE == 0 || MIN_WIDTH > FWD_MAX || FWD_MAX >= REV_MIN ||
      REV_MIN > MAX_WIDTH || MAX_WIDTH >= 2097152) begin : g_param_check
    $error("servo_pulse_decoder: inconsistent width/clock parameters");
  end

  typedef enum logic [1:0] {ARM, IDLE, HIGH} state_t;

  state_t            state, state_next;
  logic              sync1, s, p;
  logic              rise, fall;
  logic [20:0]       hcnt;
  logic [FCNT_W-1:0] fcnt;
  logic              timeout_hit;
  logic              start, count, done;
  logic              in_range;
  logic [1:0]        dir_code;

  logic [20:0] width_q;
  logic [1:0]  direction_q;
  logic        valid_q, error_q, timeout_q;

  // NOTE: the synchronizer resets to 1 so that a pulse already high at reset
  // release never looks like a rising edge; ARM then waits for it to end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      p     <= 1'b1;
    end else begin
      sync1 <= bus.pulse_in;
      s     <= sync1;
      p     <= s;
    end
  end

  assign rise        = s & ~p;
  assign fall        = ~s & p;
  assign timeout_hit = (fcnt == FT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARM;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    count      = 1'b0;
    done       = 1'b0;
    case (state)
      ARM:  if (!s) state_next = IDLE;
      IDLE: if (rise) begin
        state_next = HIGH;
        start      = 1'b1;
      end
      HIGH: begin
        if (fall) begin
          state_next = IDLE;
          done       = 1'b1;
        end else if (timeout_hit) begin
          state_next = ARM;
        end else if (s) begin
          count = 1'b1;
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_comb begin
    in_range = (hcnt >= MIN_W) && (hcnt <= MAX_W);
    if (hcnt <= FWD_W)      dir_code = DIR_FWD;
    else if (hcnt >= REV_W) dir_code = DIR_REV;
    else                    dir_code = DIR_NEUTRAL;
  end

  // A completed measurement is applied after the watchdog so a fall that
  // coincides with the timeout still lands its Valid and direction.
  // NOTE: state here is updated with <= so every register samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= '0;
      fcnt        <= '0;
      width_q     <= '0;
      direction_q <= DIR_NEUTRAL;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;

      if (rise)              fcnt <= '0;
      else if (!timeout_hit) fcnt <= fcnt + FCNT_W'(1);

      if (start)                          hcnt <= 21'd1;
      else if (count && hcnt != HCNT_MAX) hcnt <= hcnt + 21'd1;

      if (timeout_hit) begin
        timeout_q   <= 1'b1;
        direction_q <= DIR_NEUTRAL;
      end

      if (done) begin
        width_q <= hcnt;
        if (in_range) begin
          valid_q     <= 1'b1;
          timeout_q   <= 1'b0;
          direction_q <= dir_code;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.width     = width_q;
  assign bus.direction = direction_q;
  assign bus.valid     = valid_q;
  assign bus.error     = error_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with widths scaled down by 1000
// (0.8/1.25/1.75/2.2 ms -> 80/125/175/220 cycles, 30 ms -> 3000 cycles).
module tb_servo_pulse_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  servo_pulse_if bus ();

  servo_pulse_decoder #(
    .CLK_RATE     (100000),
    .MIN_WIDTH    (80),
    .FWD_MAX      (125),
    .REV_MIN      (175),
    .MAX_WIDTH    (220),
    .FRAME_TIMEOUT(3000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a high pulse of n cycles, then look for the strobe within 8 cycles.
  task automatic run_pulse(input string tag, input int n, input logic exp_v,
                           input logic exp_e, input logic [20:0] exp_w,
                           input logic [1:0] exp_d);
    int   lat;
    logic got_v, got_e;
    lat   = 0;
    got_v = 1'b0;
    got_e = 1'b0;
    @(posedge clk); #1 bus.pulse_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.pulse_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.error) begin
        lat   = i;
        got_v = bus.valid;
        got_e = bus.error;
        break;
      end
    end
    if (exp_v || exp_e) begin
      check({tag, " latency"}, lat, 3);
      check({tag, " valid"}, got_v, exp_v);
      check({tag, " error"}, got_e, exp_e);
      check({tag, " width"}, bus.width, exp_w);
      check({tag, " direction"}, bus.direction, exp_d);
      @(posedge clk); #1;
      check({tag, " strobe_len"}, bus.valid | bus.error, 0);
    end else begin
      check({tag, " no_strobe"}, lat, 0);
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int strobes;
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.valid || bus.error) strobes++;
    end
    check({tag, " strobes"}, strobes, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.pulse_in = 1'b0;
    rst = 1'b1;
    idle(3);
    check("rst width", bus.width, 0);
    check("rst direction", bus.direction, 1);
    check("rst valid", bus.valid, 0);
    check("rst error", bus.error, 0);
    check("rst timeout", bus.timeout, 1);
    rst = 1'b0;
    idle(10);

    run_pulse("fwd100", 100, 1'b1, 1'b0, 21'd100, 2'd0);
    check("fwd100 timeout", bus.timeout, 0);
    idle(5);
    run_pulse("neu150", 150, 1'b1, 1'b0, 21'd150, 2'd1);
    idle(5);
    run_pulse("rev200", 200, 1'b1, 1'b0, 21'd200, 2'd2);
    idle(5);

    run_pulse("b125", 125, 1'b1, 1'b0, 21'd125, 2'd0);
    idle(5);
    run_pulse("b126", 126, 1'b1, 1'b0, 21'd126, 2'd1);
    idle(5);
    run_pulse("b174", 174, 1'b1, 1'b0, 21'd174, 2'd1);
    idle(5);
    run_pulse("b175", 175, 1'b1, 1'b0, 21'd175, 2'd2);
    idle(5);
    run_pulse("short79", 79, 1'b0, 1'b1, 21'd79, 2'd2);
    idle(5);
    run_pulse("min80", 80, 1'b1, 1'b0, 21'd80, 2'd0);
    idle(5);
    run_pulse("max220", 220, 1'b1, 1'b0, 21'd220, 2'd2);
    idle(5);
    run_pulse("long221", 221, 1'b0, 1'b1, 21'd221, 2'd2);
    check("long221 timeout", bus.timeout, 0);
    idle(5);

    // Watchdog: counter clears 3 edges after the rise, Timeout lands 3004 edges after it.
    run_pulse("wd_rev200", 200, 1'b1, 1'b0, 21'd200, 2'd2);
    idle(2799);
    check("wd before timeout", bus.timeout, 0);
    check("wd before direction", bus.direction, 2);
    idle(1);
    check("wd timeout", bus.timeout, 1);
    check("wd direction", bus.direction, 1);
    idle(50);
    run_pulse("wd_recover", 100, 1'b1, 1'b0, 21'd100, 2'd0);
    check("wd_recover timeout", bus.timeout, 0);
    idle(5);

    // Input stuck high: measurement abandoned without any strobe.
    @(posedge clk); #1 bus.pulse_in = 1'b1;
    watch_quiet("stuck high", 3100);
    check("stuck timeout", bus.timeout, 1);
    check("stuck direction", bus.direction, 1);
    bus.pulse_in = 1'b0;
    watch_quiet("stuck release", 10);
    run_pulse("after_stuck", 150, 1'b1, 1'b0, 21'd150, 2'd1);
    check("after_stuck timeout", bus.timeout, 0);
    idle(5);

    // Reset in the middle of a pulse, released while still high.
    @(posedge clk); #1 bus.pulse_in = 1'b1;
    idle(50);
    #2 rst = 1'b1;
    #1;
    check("midrst width", bus.width, 0);
    check("midrst direction", bus.direction, 1);
    check("midrst timeout", bus.timeout, 1);
    check("midrst valid", bus.valid, 0);
    idle(3);
    rst = 1'b0;
    idle(150);
    bus.pulse_in = 1'b0;
    watch_quiet("partial pulse", 10);
    run_pulse("post_rst", 100, 1'b1, 1'b0, 21'd100, 2'd0);
    check("post_rst timeout", bus.timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
